// File: rtl/cache_fill_fsm.sv
// Cache miss fill initiator: fetches the aligned block holding the miss address,
// one word read per cycle, steers returned words into the data array, then writes the tag.
module cache_fill_fsm #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned OFFSET_BITS = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   miss_detected,
  input  logic [ADDR_WIDTH-1:0]  miss_address,
  input  logic                   memory_data_valid,
  input  logic [15:0]            memory_data,
  output logic                   fsm_busy,
  output logic                   memory_en,
  output logic                   memory_wr,
  output logic [ADDR_WIDTH-1:0]  memory_address,
  output logic                   write_data_array,
  output logic [OFFSET_BITS-1:0] cache_word_offset,
  output logic [15:0]            cache_data_out,
  output logic                   write_tag_array
);

  // Byte-offset bits within a block: word offset plus the byte-in-word bit.
  localparam int unsigned BlockBits = OFFSET_BITS + 1;

  typedef enum logic [0:0] {StIdle, StFill} state_e;

  state_e                 r_state;
  logic [OFFSET_BITS:0]   r_issue_cnt;
  logic [OFFSET_BITS-1:0] r_recv_cnt;
  logic [ADDR_WIDTH-1:0]  r_base;

  logic                   w_fill;
  logic                   w_issue;
  logic                   w_recv;
  logic                   w_last;
  logic [ADDR_WIDTH-1:0]  w_word_addr;

  assign w_fill  = (r_state == StFill);
  // The MSB of the issue counter marks that every word of the block has been requested.
  assign w_issue = w_fill && !r_issue_cnt[OFFSET_BITS];
  assign w_recv  = w_fill && memory_data_valid;
  assign w_last  = w_recv && (&r_recv_cnt);

  // Base is block aligned, so OR-ing in the word offset never carries.
  assign w_word_addr = r_base |
                       {{(ADDR_WIDTH-BlockBits){1'b0}}, r_issue_cnt[OFFSET_BITS-1:0], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
      r_base      <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (miss_detected) begin
            r_state     <= StFill;
            r_base      <= {miss_address[ADDR_WIDTH-1:BlockBits], {BlockBits{1'b0}}};
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
          end
        end
        StFill: begin
          if (w_issue) begin
            r_issue_cnt <= r_issue_cnt + 1'b1;
          end
          if (w_recv) begin
            r_recv_cnt <= r_recv_cnt + 1'b1;
          end
          if (w_last) begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign fsm_busy          = w_fill;
  assign memory_en         = w_issue;
  assign memory_wr         = 1'b0;
  assign memory_address    = w_issue ? w_word_addr : '0;
  assign write_data_array  = w_recv;
  assign cache_word_offset = w_recv ? r_recv_cnt : '0;
  assign cache_data_out    = w_recv ? memory_data : '0;
  assign write_tag_array   = w_last;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Randomized bench for cache_fill_fsm: memory responder, queue-based reference model,
// per-cycle output comparison and literal checks on directed fills.
module tb_cache_fill_fsm;

  logic        clk;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fsm_busy;
  logic        memory_en;
  logic        memory_wr;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  cache_word_offset;
  logic [15:0] cache_data_out;
  logic        write_tag_array;

  cache_fill_fsm #(
    .ADDR_WIDTH (16),
    .OFFSET_BITS(3)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .miss_detected    (miss_detected),
    .miss_address     (miss_address),
    .memory_data_valid(memory_data_valid),
    .memory_data      (memory_data),
    .fsm_busy         (fsm_busy),
    .memory_en        (memory_en),
    .memory_wr        (memory_wr),
    .memory_address   (memory_address),
    .write_data_array (write_data_array),
    .cache_word_offset(cache_word_offset),
    .cache_data_out   (cache_data_out),
    .write_tag_array  (write_tag_array)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory knobs set by the stimulus process.
  int          lat = 4;
  bit          gap = 1'b0;
  bit          spurious = 1'b0;
  logic [15:0] salt = 16'hA000;

  typedef struct {
    logic [15:0] addr;
    int          due;
  } req_t;

  req_t        pend[$];
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: in-order returns, no earlier than lat cycles after the request.
  always @(posedge clk) begin
    #1;
    memory_data_valid = 1'b0;
    memory_data       = 16'h0;
    if (rst_n && pend.size() > 0 && pend[0].due <= cyc && (!gap || $urandom_range(1, 0) == 1)) begin
      memory_data_valid = 1'b1;
      memory_data       = salt + 16'(pend[0].addr[3:1]);
      void'(pend.pop_front());
    end else if (spurious) begin
      memory_data_valid = 1'b1;
      memory_data       = 16'($urandom);
    end
  end

  // Reference model: outstanding request addresses of the current fill and words received.
  bit          m_busy = 1'b0;
  logic [15:0] m_req[$];
  int          m_recv = 0;

  // Observation logs of DUT activity, read by the directed checks.
  logic [15:0] addr_log[$];
  int          off_log[$];
  logic [15:0] data_log[$];
  int          busy_cycles = 0;
  int          wr_count = 0;
  int          tag_count = 0;
  int          tag_off = 0;
  logic [15:0] tag_data = 16'h0;

  logic        e_busy, e_en, e_wr, e_tag;
  logic [15:0] e_addr, e_data;
  int          e_off;
  req_t        new_req;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_recv = 0;
      m_req.delete();
      pend.delete();
      e_busy = 1'b0; e_en = 1'b0; e_wr = 1'b0; e_tag = 1'b0;
      e_addr = 16'h0; e_data = 16'h0; e_off = 0;
    end else begin
      e_busy = m_busy;
      e_en   = m_busy && m_req.size() > 0;
      e_addr = e_en ? m_req[0] : 16'h0;
      e_wr   = m_busy && memory_data_valid;
      e_off  = e_wr ? m_recv : 0;
      e_data = e_wr ? memory_data : 16'h0;
      e_tag  = e_wr && m_recv == 7;
    end

    chk("fsm_busy", int'(fsm_busy), int'(e_busy));
    chk("memory_en", int'(memory_en), int'(e_en));
    chk("memory_wr", int'(memory_wr), 0);
    chk("memory_address", int'(memory_address), int'(e_addr));
    chk("write_data_array", int'(write_data_array), int'(e_wr));
    chk("cache_word_offset", int'(cache_word_offset), e_off);
    chk("cache_data_out", int'(cache_data_out), int'(e_data));
    chk("write_tag_array", int'(write_tag_array), int'(e_tag));

    if (fsm_busy) busy_cycles++;
    if (memory_en) addr_log.push_back(memory_address);
    if (write_data_array) begin
      wr_count++;
      off_log.push_back(int'(cache_word_offset));
      data_log.push_back(cache_data_out);
    end
    if (write_tag_array) begin
      tag_count++;
      tag_off  = int'(cache_word_offset);
      tag_data = cache_data_out;
    end

    if (rst_n) begin
      if (e_en) begin
        new_req.addr = e_addr;
        new_req.due  = cyc + lat;
        pend.push_back(new_req);
        void'(m_req.pop_front());
      end
      if (e_wr) m_recv++;
      if (e_tag) begin
        m_busy = 1'b0;
      end else if (!e_busy && miss_detected) begin
        m_busy = 1'b1;
        m_recv = 0;
        m_req.delete();
        for (int i = 0; i < 8; i++) m_req.push_back((miss_address & 16'hFFF0) + 16'(2 * i));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Hold the miss until the tag write has been seen, then drop it.
  task automatic wait_tag(input string nm);
    int t0;
    bit seen;
    t0 = tag_count;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      step(1);
      if (tag_count > t0) seen = 1'b1;
    end
    if (!seen) chk({nm, "_tag_timeout"}, 0, 1);
    miss_detected = 1'b0;
  endtask

  task automatic start_fill(input logic [15:0] a);
    miss_address  = a;
    miss_detected = 1'b1;
  endtask

  int a0, w0, b0, t0;

  initial begin
    rst_n         = 1'b0;
    miss_detected = 1'b1;
    miss_address  = 16'h1234;
    memory_data_valid = 1'b0;
    memory_data   = 16'h0;
    step(3);
    miss_detected = 1'b0;
    rst_n = 1'b1;
    step(2);
    chk("idle_after_reset_busy", int'(fsm_busy), 0);

    // Valids while idle must not write anything.
    w0 = wr_count;
    spurious = 1'b1;
    step(4);
    spurious = 1'b0;
    step(1);
    chk("spurious_writes", wr_count - w0, 0);

    // Basic fill, fixed 4-cycle memory.
    a0 = addr_log.size(); w0 = wr_count; b0 = busy_cycles; t0 = tag_count;
    lat = 4; gap = 1'b0; salt = 16'hA000;
    start_fill(16'h1234);
    wait_tag("basic");
    step(2);
    chk("basic_busy_cycles", busy_cycles - b0, 12);
    chk("basic_req_count", addr_log.size() - a0, 8);
    chk("basic_addr_first", int'(addr_log[a0]), 16'h1230);
    chk("basic_addr_last", int'(addr_log[a0+7]), 16'h123E);
    for (int i = 0; i < 8; i++) begin
      chk("basic_offset", off_log[w0+i], i);
      chk("basic_data", int'(data_log[w0+i]), 16'hA000 + i);
    end
    chk("basic_tag_count", tag_count - t0, 1);
    chk("basic_tag_off", tag_off, 7);
    chk("basic_tag_data", int'(tag_data), 16'hA007);

    // Gapped returns with miss_address moved mid-fill.
    a0 = addr_log.size(); w0 = wr_count; b0 = busy_cycles; t0 = tag_count;
    lat = 3; gap = 1'b1; salt = 16'h5100;
    start_fill(16'h0456);
    step(3);
    miss_address = 16'h4000;
    wait_tag("gapped");
    step(2);
    chk("gap_addr_first", int'(addr_log[a0]), 16'h0450);
    chk("gap_addr_last", int'(addr_log[a0+7]), 16'h045E);
    for (int i = 0; i < 8; i++) chk("gap_offset", off_log[w0+i], i);
    chk("gap_tag_count", tag_count - t0, 1);
    chk("gap_busy_ge12", int'(busy_cycles - b0 >= 12), 1);

    // Top of address space: no wrap.
    a0 = addr_log.size();
    lat = 2; gap = 1'b0;
    start_fill(16'hFFFF);
    wait_tag("top");
    step(2);
    chk("top_addr_first", int'(addr_log[a0]), 16'hFFF0);
    chk("top_addr_last", int'(addr_log[a0+7]), 16'hFFFE);

    // Reset after three returned words: tag must never be written.
    w0 = wr_count; t0 = tag_count;
    lat = 2; gap = 1'b0;
    start_fill(16'h0800);
    for (int i = 0; i < 100 && wr_count - w0 < 3; i++) step(1);
    chk("rst_mid_three_writes", int'(wr_count - w0 >= 3), 1);
    rst_n = 1'b0;
    miss_detected = 1'b0;
    #1;
    chk("rst_mid_busy", int'(fsm_busy), 0);
    chk("rst_mid_en", int'(memory_en), 0);
    step(2);
    chk("rst_mid_no_tag", tag_count - t0, 0);
    rst_n = 1'b1;
    step(2);
    a0 = addr_log.size(); w0 = wr_count;
    start_fill(16'h0020);
    wait_tag("after_reset");
    step(2);
    chk("restart_addr", int'(addr_log[a0]), 16'h0020);
    chk("restart_offset", off_log[w0], 0);

    // Random fills; sometimes the miss lingers one cycle and starts a back-to-back fill.
    for (int n = 0; n < 25; n++) begin
      lat  = $urandom_range(6, 1);
      gap  = 1'($urandom_range(1, 0));
      salt = 16'($urandom);
      start_fill(16'($urandom));
      wait_tag("rand");
      if ($urandom_range(3, 0) == 0) begin
        miss_detected = 1'b1;
        step(1);
        miss_detected = 1'b0;
        t0 = tag_count;
        for (int i = 0; i < 300 && tag_count == t0; i++) step(1);
        chk("rand_refill_tag", int'(tag_count > t0), 1);
      end
      spurious = 1'($urandom_range(1, 0));
      step($urandom_range(3, 1));
      spurious = 1'b0;
    end
    step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
